// File: rtl/vga_fb_pkg.sv
// Shared types and helpers for the framebuffer scheduler.
// Latency: n/a (types and a pure function).
// Backpressure: n/a.
package vga_fb_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    localparam int FB_W_DEFAULT = 480;
    localparam int FB_H_DEFAULT = 270;
    localparam int FB_WORDS     = FB_W_DEFAULT * FB_H_DEFAULT;
    localparam int PIPE_LAT     = 3;

    // Raster position -> framebuffer word, dropping the replication bits of each axis.
    function automatic logic [31:0] disp_addr(
        input logic [11:0] h,
        input logic [11:0] v,
        input int          scale_log2,
        input int          fb_w
    );
        logic [31:0] row;
        logic [31:0] col;
        row = 32'(v) >> scale_log2;
        col = 32'(h) >> scale_log2;
        return row * 32'(fb_w) + col;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Shift register delaying hsync/vsync/video_on to line up with pixel data.
// Latency: DEPTH cycles.
// Backpressure: none, free-running.
module vga_sync_delay
    import vga_fb_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEPTH = PIPE_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/vga_fb_scheduler.sv
// Arbitrates the framebuffer RAM between display fetch (fixed priority) and a pixel writer.
// Latency: counters to rgb/syncs 3 cycles; accepted write reaches mem_* next cycle.
// Backpressure: wr_ready drops on display claim cycles (and active video when WR_ONLY_BLANK).
module vga_fb_scheduler
    import vga_fb_pkg::*;
#(
    parameter int FB_W          = FB_W_DEFAULT,
    parameter int FB_H          = FB_H_DEFAULT,
    parameter int SCALE_LOG2    = 2,
    parameter int ADDR_W        = 17,
    parameter bit WR_ONLY_BLANK = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [11:0]       h_count,
    input  logic [11:0]       v_count,
    input  logic              video_on,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [11:0]       wr_data,
    output logic              wr_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [11:0]       mem_wdata,
    input  logic [11:0]       mem_rdata,
    output logic [11:0]       rgb,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              video_on_o
);

    localparam logic [11:0] PIX_MASK = 12'((1 << SCALE_LOG2) - 1);
    localparam int          N_WORDS  = FB_W * FB_H;

    logic              disp;
    logic              wr_fire;
    logic              wr_in_range;
    logic [ADDR_W-1:0] disp_addr_w;
    logic              rd_q1, rd_q2;
    logic              vo_q1, vo_q2;
    rgb444_t           rgb_q;

    assign disp        = video_on && ((h_count & PIX_MASK) == 12'd0);
    assign disp_addr_w = ADDR_W'(disp_addr(h_count, v_count, SCALE_LOG2, FB_W));

    // Held low in reset so a handshake can never complete while the write would be discarded.
    assign wr_ready    = !rst && !disp && (!WR_ONLY_BLANK || !video_on);
    assign wr_fire     = wr_valid && wr_ready;
    assign wr_in_range = 32'(wr_addr) < 32'(N_WORDS);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wr_err    <= 1'b0;
            rd_q1     <= 1'b0;
            rd_q2     <= 1'b0;
            vo_q1     <= 1'b0;
            vo_q2     <= 1'b0;
            rgb_q     <= '0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            wr_err <= 1'b0;
            if (disp) begin
                mem_en   <= 1'b1;
                mem_addr <= disp_addr_w;
            end else if (wr_fire && wr_in_range) begin
                mem_en    <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end else if (wr_fire) begin
                wr_err <= 1'b1;
            end

            // Read tag and active flag follow the access so rgb lands with the delayed syncs.
            rd_q1 <= disp;
            rd_q2 <= rd_q1;
            vo_q1 <= video_on;
            vo_q2 <= vo_q1;
            if (!vo_q2)
                rgb_q <= '0;
            else if (rd_q2)
                rgb_q <= mem_rdata;
        end
    end

    assign rgb = rgb_q;

    vga_sync_delay #(
        .WIDTH (3),
        .DEPTH (PIPE_LAT)
    ) u_sync_delay (
        .clk  (clk),
        .rst  (rst),
        .din  ({hsync, vsync, video_on}),
        .dout ({hsync_o, vsync_o, video_on_o})
    );

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Directed bench for vga_fb_scheduler: cycle-tagged scoreboard checked by a negedge monitor.
module tb_vga_fb_scheduler;

    localparam int ADDR_W = 17;

    localparam int S_MEM_EN = 0, S_MEM_WE = 1, S_MEM_ADDR = 2, S_MEM_WDATA = 3, S_RGB = 4,
                   S_WR_ERR = 5, S_WR_READY = 6, S_HS = 7, S_VS = 8, S_VO = 9,
                   S_B_WR_READY = 10, S_B_MEM_EN = 11, S_B_MEM_WE = 12, S_B_MEM_ADDR = 13,
                   S_B_MEM_WDATA = 14, S_B_WR_ERR = 15, S_B_RGB = 16, S_B_HS = 17,
                   S_B_VS = 18, S_B_VO = 19;

    logic              clk = 1'b0;
    logic              rst;
    logic [11:0]       h_count, v_count;
    logic              video_on, hsync, vsync;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [11:0]       wr_data;
    logic [11:0]       mem_rdata = 12'h000;

    logic              wr_ready, wr_err, mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [11:0]       mem_wdata, rgb;
    logic              hsync_o, vsync_o, video_on_o;

    logic              wr_ready_b, wr_err_b, mem_en_b, mem_we_b;
    logic [ADDR_W-1:0] mem_addr_b;
    logic [11:0]       mem_wdata_b, rgb_b;
    logic              hsync_o_b, vsync_o_b, video_on_o_b;

    typedef struct {
        int    cyc;
        int    sig;
        int    val;
        string nm;
    } sb_t;

    sb_t         sb[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] ram [int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Read-only RAM model: data one cycle after a read enable.
    always @(posedge clk) begin
        if (mem_en && !mem_we)
            mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : 12'h000;
    end

    vga_fb_scheduler #(.WR_ONLY_BLANK(1'b0)) dut (
        .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count), .video_on(video_on),
        .hsync(hsync), .vsync(vsync), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rgb(rgb), .hsync_o(hsync_o), .vsync_o(vsync_o), .video_on_o(video_on_o)
    );

    vga_fb_scheduler #(.WR_ONLY_BLANK(1'b1)) dut_b (
        .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count), .video_on(video_on),
        .hsync(hsync), .vsync(vsync), .wr_valid(wr_valid), .wr_ready(wr_ready_b),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err_b), .mem_en(mem_en_b),
        .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata),
        .rgb(rgb_b), .hsync_o(hsync_o_b), .vsync_o(vsync_o_b), .video_on_o(video_on_o_b)
    );

    function automatic int peek(input int s);
        case (s)
            S_MEM_EN:      return int'(mem_en);
            S_MEM_WE:      return int'(mem_we);
            S_MEM_ADDR:    return int'(mem_addr);
            S_MEM_WDATA:   return int'(mem_wdata);
            S_RGB:         return int'(rgb);
            S_WR_ERR:      return int'(wr_err);
            S_WR_READY:    return int'(wr_ready);
            S_HS:          return int'(hsync_o);
            S_VS:          return int'(vsync_o);
            S_VO:          return int'(video_on_o);
            S_B_WR_READY:  return int'(wr_ready_b);
            S_B_MEM_EN:    return int'(mem_en_b);
            S_B_MEM_WE:    return int'(mem_we_b);
            S_B_MEM_ADDR:  return int'(mem_addr_b);
            S_B_MEM_WDATA: return int'(mem_wdata_b);
            S_B_WR_ERR:    return int'(wr_err_b);
            S_B_RGB:       return int'(rgb_b);
            S_B_HS:        return int'(hsync_o_b);
            S_B_VS:        return int'(vsync_o_b);
            S_B_VO:        return int'(video_on_o_b);
            default:       return -1;
        endcase
    endfunction

    // Monitor: compare every expectation tagged for the current cycle.
    always @(negedge clk) begin : monitor
        int i;
        int got;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                got = peek(sb[i].sig);
                n_cmp++;
                if (got !== sb[i].val) begin
                    n_bad++;
                    $display("FAIL %s cycle %0d: got 0x%0h required 0x%0h",
                             sb[i].nm, cyc, got, sb[i].val);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s cycle %0d: never sampled (due cycle %0d)", sb[i].nm, cyc, sb[i].cyc);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic exp_at(input int dc, input int sig, input int val, input string nm);
        sb_t e;
        e.cyc = cyc + dc;
        e.sig = sig;
        e.val = val;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic drv(input int h, input int v, input bit vo, input bit hs, input bit vs);
        h_count  = 12'(h);
        v_count  = 12'(v);
        video_on = vo;
        hsync    = hs;
        vsync    = vs;
    endtask

    task automatic wr(input bit vld, input int a, input int d);
        wr_valid = vld;
        wr_addr  = ADDR_W'(a);
        wr_data  = 12'(d);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        ram[0]    = 12'hABC;
        ram[1]    = 12'h456;
        ram[481]  = 12'h777;
        ram[5785] = 12'hDEF;

        // Power-on reset
        rst = 1'b1;
        drv(0, 0, 0, 0, 0);
        wr(0, 0, 0);
        tick; tick;
        exp_at(1, S_MEM_EN, 0, "por_mem_en");
        tick;
        rst = 1'b0;

        // Display fetch at origin, rgb held for the replicated pixels
        drv(0, 0, 1, 0, 0);
        exp_at(0, S_WR_READY, 0, "claim_ready");
        exp_at(1, S_MEM_EN, 1, "fetch0_en");
        exp_at(1, S_MEM_WE, 0, "fetch0_we");
        exp_at(1, S_MEM_ADDR, 0, "fetch0_addr");
        for (int k = 3; k <= 6; k++) exp_at(k, S_RGB, 'hABC, "fetch0_rgb");
        exp_at(7, S_RGB, 'h456, "fetch1_rgb");
        tick;

        // Free-slot write at h=1
        drv(1, 0, 1, 0, 0);
        wr(1, 100, 'h123);
        exp_at(0, S_WR_READY, 1, "free_ready");
        exp_at(0, S_B_WR_READY, 0, "blank_only_active_h1");
        exp_at(1, S_MEM_EN, 1, "free_en");
        exp_at(1, S_MEM_WE, 1, "free_we");
        exp_at(1, S_MEM_ADDR, 100, "free_addr");
        exp_at(1, S_MEM_WDATA, 'h123, "free_wdata");
        exp_at(1, S_B_MEM_EN, 0, "blank_only_no_issue");
        tick;
        wr(0, 0, 0);
        for (int h = 2; h <= 7; h++) begin
            drv(h, 0, 1, 0, 0);
            exp_at(0, S_B_WR_READY, 0, "blank_only_active");
            if (h == 4) exp_at(1, S_MEM_ADDR, 1, "fetch1_addr");
            tick;
        end

        // Collision: writer waits out the display slot at h=8
        drv(8, 0, 1, 0, 0);
        wr(1, 200, 'h5A5);
        exp_at(0, S_WR_READY, 0, "coll_stall");
        exp_at(1, S_MEM_EN, 1, "coll_rd_en");
        exp_at(1, S_MEM_WE, 0, "coll_rd_we");
        exp_at(1, S_MEM_ADDR, 2, "coll_rd_addr");
        tick;
        drv(9, 0, 1, 0, 0);
        exp_at(0, S_WR_READY, 1, "coll_grant");
        exp_at(1, S_MEM_WE, 1, "coll_wr_we");
        exp_at(1, S_MEM_ADDR, 200, "coll_wr_addr");
        exp_at(1, S_MEM_WDATA, 'h5A5, "coll_wr_wdata");
        tick;
        wr(0, 0, 0);
        drv(10, 0, 1, 0, 0); tick;
        drv(11, 0, 1, 0, 0); tick;

        // Second-row address and sync alignment with the fetched pixel
        drv(4, 5, 1, 1, 1);
        exp_at(1, S_MEM_EN, 1, "row_en");
        exp_at(1, S_MEM_ADDR, 481, "row_addr");
        exp_at(2, S_HS, 0, "hs_early");
        exp_at(3, S_HS, 1, "hs_align");
        exp_at(3, S_VS, 1, "vs_align");
        exp_at(3, S_VO, 1, "vo_align");
        exp_at(3, S_RGB, 'h777, "row_rgb");
        exp_at(3, S_B_HS, 1, "b_hs_align");
        exp_at(3, S_B_RGB, 'h777, "b_row_rgb");
        exp_at(6, S_RGB, 'h777, "row_rgb_hold");
        tick;
        for (int h = 5; h <= 7; h++) begin
            drv(h, 5, 1, 1, 1);
            tick;
        end

        // Blanking: out-of-range write, then an in-range write in blank-only mode
        drv(1950, 5, 0, 1, 1);
        wr(1, 129600, 'hFFF);
        exp_at(0, S_WR_READY, 1, "oor_ready");
        exp_at(0, S_B_WR_READY, 1, "blank_ready0");
        exp_at(1, S_WR_ERR, 1, "oor_err");
        exp_at(1, S_MEM_EN, 0, "oor_no_en");
        exp_at(1, S_B_WR_ERR, 1, "b_oor_err");
        exp_at(1, S_B_MEM_EN, 0, "b_oor_no_en");
        exp_at(2, S_WR_ERR, 0, "oor_err_pulse");
        exp_at(3, S_RGB, 0, "blank_rgb");
        exp_at(3, S_VO, 0, "blank_vo");
        exp_at(3, S_B_VS, 1, "b_vs");
        exp_at(3, S_B_VO, 0, "b_blank_vo");
        tick;
        drv(1951, 5, 0, 1, 1);
        wr(1, 300, 'h9C3);
        exp_at(0, S_B_WR_READY, 1, "blank_ready1");
        exp_at(1, S_B_MEM_EN, 1, "b_wr_en");
        exp_at(1, S_B_MEM_WE, 1, "b_wr_we");
        exp_at(1, S_B_MEM_ADDR, 300, "b_wr_addr");
        exp_at(1, S_B_MEM_WDATA, 'h9C3, "b_wr_wdata");
        exp_at(1, S_MEM_WE, 1, "blank_wr_we");
        exp_at(2, S_B_WR_ERR, 0, "b_oor_err_pulse");
        tick;
        wr(0, 0, 0);
        drv(1952, 5, 0, 1, 1);
        exp_at(0, S_B_WR_READY, 1, "blank_ready2");
        tick;
        drv(1953, 5, 0, 1, 1); tick;

        // Mid-frame reset with a read in flight and the writer pending
        drv(100, 50, 1, 1, 1);
        tick;
        rst = 1'b1;
        wr(1, 50, 'h111);
        exp_at(1, S_MEM_EN, 0, "rst_mem_en");
        exp_at(1, S_MEM_WE, 0, "rst_mem_we");
        exp_at(1, S_MEM_ADDR, 0, "rst_mem_addr");
        exp_at(1, S_MEM_WDATA, 0, "rst_mem_wdata");
        exp_at(1, S_RGB, 0, "rst_rgb");
        exp_at(1, S_WR_ERR, 0, "rst_wr_err");
        exp_at(1, S_HS, 0, "rst_hs");
        exp_at(1, S_VS, 0, "rst_vs");
        exp_at(1, S_VO, 0, "rst_vo");
        exp_at(2, S_RGB, 0, "rst_rgb_after");
        tick;
        tick;
        rst = 1'b0;
        drv(101, 50, 1, 1, 1);
        exp_at(0, S_MEM_WE, 0, "rel_no_we");
        exp_at(0, S_WR_READY, 1, "rel_ready");
        exp_at(0, S_B_WR_READY, 0, "rel_b_ready");
        exp_at(1, S_MEM_WE, 1, "rel_wr_we");
        exp_at(1, S_MEM_ADDR, 50, "rel_wr_addr");
        exp_at(1, S_MEM_WDATA, 'h111, "rel_wr_wdata");
        exp_at(2, S_HS, 0, "rel_hs_cleared");
        exp_at(3, S_HS, 1, "rel_hs_first");
        tick;
        wr(0, 0, 0);
        for (int h = 102; h <= 104; h++) begin
            drv(h, 50, 1, 1, 1);
            tick;
        end

        for (int k = 0; k < 10 && sb.size() > 0; k++) tick;
        while (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: not sampled, due cycle %0d", sb[0].nm, sb[0].cyc);
            void'(sb.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_fb_scheduler.md
Name: vga_fb_scheduler

Overview:
- Owns the single-port framebuffer RAM and shares it between two requesters:
  - display fetch, driven by the timing generator's counters, fixed highest priority;
  - a pixel writer (CPU/drawing engine) using a valid/ready handshake.
- Upscales a FB_W x FB_H framebuffer by 2^SCALE_LOG2 to the display raster.
- Emits registered RGB444 plus hsync/vsync/video_on delayed to align with the pixel data.
- Sits between the VGA timing generator and the board VGA pins.

Parameters:
- FB_W, 480, framebuffer width in pixels (H_RES = FB_W << SCALE_LOG2)
- FB_H, 270, framebuffer height in pixels (V_RES = FB_H << SCALE_LOG2)
- SCALE_LOG2, 2, log2 of the replication factor in both axes
- ADDR_W, 17, framebuffer word address width (>= clog2(FB_W*FB_H))
- WR_ONLY_BLANK, 0, when 1 the writer is granted only outside the active video area

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- h_count  in  12  horizontal counter from timing generator
- v_count  in  12  vertical counter from timing generator
- video_on  in  1  active-area flag from timing generator
- hsync  in  1  hsync from timing generator
- vsync  in  1  vsync from timing generator
- wr_valid  in  1  writer request
- wr_ready  out  1  writer grant (combinational)
- wr_addr  in  ADDR_W  writer word address
- wr_data  in  12  writer pixel, RGB444
- wr_err  out  1  one-cycle pulse: accepted write had an out-of-range address
- mem_en  out  1  RAM enable (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_wdata  out  12  RAM write data (registered)
- mem_rdata  in  12  RAM read data, valid the cycle after mem_en with mem_we=0
- rgb  out  12  pixel output (registered)
- hsync_o, vsync_o, video_on_o  out  1 each  syncs delayed by 3 cycles

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: mem_en, mem_we, mem_addr, mem_wdata, rgb, wr_err, hsync_o, vsync_o, video_on_o = 0; sync delay line cleared. Reset mid-frame aborts any pending access; no write is issued in the cycle after reset deasserts.
- Display claim (combinational): disp = video_on && (h_count[SCALE_LOG2-1:0] == 0).
- Display address: (v_count >> SCALE_LOG2) * FB_W + (h_count >> SCALE_LOG2), computed at ADDR_W width.
- Grant: wr_ready = !disp && (!WR_ONLY_BLANK || !video_on). It never depends on wr_valid. Handshake: a write is accepted when wr_valid && wr_ready. The writer holds addr/data stable until accepted.
- Issue cycle t, registered into the mem_* outputs at the end of t:
  - if disp: mem_en=1, mem_we=0, mem_addr = display address;
  - else if the write is accepted and wr_addr < FB_W*FB_H: mem_en=1, mem_we=1, mem_addr/mem_wdata from the writer;
  - else if the write is accepted and wr_addr is out of range: mem_en=0, wr_err=1 for one cycle, write dropped;
  - else: mem_en=0, mem_we=0.
- Pipeline: counters at t, RAM access at t+1, mem_rdata at t+2, rgb updated at the end of t+2 (visible at t+3).
- rgb loads mem_rdata only for display reads. It holds the value for the remaining 2^SCALE_LOG2-1 pixels.
- rgb is forced to 0 whenever the delayed video_on is 0.
- hsync_o/vsync_o/video_on_o = inputs delayed exactly 3 cycles, keeping syncs aligned with rgb.
- Line wrap: the display address recomputes from v_count at each line. Rows are replicated 2^SCALE_LOG2 times with no state.
- Simultaneous events: the display always wins; a writer stalled by a display slot is granted on the next non-claim cycle.
- Bandwidth: with WR_ONLY_BLANK=0 the writer gets (2^SCALE_LOG2-1)/2^SCALE_LOG2 of active cycles plus all blanking cycles.

Decomposition:
- Package vga_fb_pkg holds:
  - rgb444_t (12-bit struct r/g/b);
  - localparams FB_WORDS = FB_W*FB_H and PIPE_LAT = 3;
  - a function computing the display address.
- Sub-module vga_sync_delay: parameterised-depth shift register for hsync/vsync/video_on, reset to 0.

Test Plan:
- Reset: rst=1 for 2 cycles mid-frame (h=100, v=50) -> all outputs 0 at the next edge; no mem_we in the first cycle after release.
- Display fetch: h=0, v=0, video_on=1 -> next cycle mem_en=1, mem_we=0, mem_addr=0. mem_rdata=0xABC -> rgb=0xABC from t+3 for 4 cycles. h=4, v=5 -> mem_addr=481.
- Free-slot write: h=1 in active area, wr_valid, wr_addr=100, wr_data=0x123 -> wr_ready=1; next cycle mem_en=1, mem_we=1, mem_addr=100, mem_wdata=0x123.
- Collision: wr_valid held from h=8 -> wr_ready=0 at h=8, display read issued; write accepted at h=9 and issued the following cycle.
- Blank-only mode (WR_ONLY_BLANK=1): wr_ready=0 for every active cycle; h=1950 (blanking) -> wr_ready=1 each cycle.
- Out of range: wr_addr=129600 accepted -> wr_err pulses for one cycle, mem_en stays 0.
- Sync alignment: hsync rises at t -> hsync_o rises at t+3, coincident with the first rgb of that pixel.
